// File: rtl/reg_dump_scanner_pkg.sv
// Shared types and constants for the register-dump scanner: state encoding,
// default widths and the byte-select helper used by the LED mux.
package reg_dump_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SHOW  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int ADDR_W_DEF     = 5;
   localparam int DATA_W_DEF     = 32;
   localparam int BYTES_PER_WORD = 4;

   function automatic logic [7:0] byte_of(input logic [DATA_W_DEF-1:0] word,
                                          input logic [1:0]            sel);
      return word[8*sel +: 8];
   endfunction

endpackage

// File: rtl/reg_dump_scanner_dwell_timer.sv
// Dwell counter: counts enabled cycles from 0 up to DWELL-1 and flags the
// terminal cycle with a one-cycle expire, then wraps back to 0.
module dwell_timer #(
   parameter int unsigned DWELL = 50000000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expire is gated by enable so a held (paused) terminal count never advances.
   always_comb begin
      cnt_d  = cnt_q;
      expire = en && (cnt_q == CNT_LAST);
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = expire ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reg_dump_scanner.sv
// Walks a wrapping range of register-file addresses, latches each word and
// shows it on the LEDs one byte at a time, most-significant byte first.
//
// state | meaning
// IDLE  | waiting for Start; LED dark
// LATCH | R_Addr = cur_addr, capture R_Data into data_q
// SHOW  | display data_q byte Byte_Sel for DWELL unpaused cycles per byte
// DONE  | one-cycle Done pulse, then back to IDLE
module reg_dump_scanner
   import reg_dump_scanner_pkg::*;
#(
   parameter int          ADDR_W = ADDR_W_DEF,
   parameter int          DATA_W = DATA_W_DEF,
   parameter int unsigned DWELL  = 50000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Pause,
   input  logic [ADDR_W-1:0] Addr_First,
   input  logic [ADDR_W-1:0] Addr_Last,
   output logic [ADDR_W-1:0] R_Addr,
   input  logic [DATA_W-1:0] R_Data,
   output logic [7:0]        LED,
   output logic [1:0]        Byte_Sel,
   output logic              Busy,
   output logic              Done
);

   localparam logic [1:0] TOP_BYTE = 2'(BYTES_PER_WORD - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        byte_sel_q, byte_sel_d;
   logic              dwell_en, dwell_clr, dwell_expire;

   assign dwell_en  = (state_q == SHOW) && !Pause;
   assign dwell_clr = (state_q == LATCH);

   dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
      .Clk    (Clk),
      .Reset  (Reset),
      .en     (dwell_en),
      .clr    (dwell_clr),
      .expire (dwell_expire)
   );

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      last_addr_d = last_addr_q;
      data_d      = data_q;
      byte_sel_d  = byte_sel_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               cur_addr_d  = Addr_First;
               last_addr_d = Addr_Last;
               state_d     = LATCH;
            end
         end
         LATCH: begin
            data_d     = R_Data;
            byte_sel_d = TOP_BYTE;
            state_d    = SHOW;
         end
         SHOW: begin
            if (dwell_expire) begin
               if (byte_sel_q != 2'd0) begin
                  byte_sel_d = byte_sel_q - 1'b1;
               end else if (cur_addr_q != last_addr_q) begin
                  // Natural wrap of the address counter gives the 31 -> 0 range walk.
                  cur_addr_d = cur_addr_q + 1'b1;
                  state_d    = LATCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         last_addr_q <= '0;
         data_q      <= '0;
         byte_sel_q  <= TOP_BYTE;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         last_addr_q <= last_addr_d;
         data_q      <= data_d;
         byte_sel_q  <= byte_sel_d;
      end
   end

   assign R_Addr   = cur_addr_q;
   assign Byte_Sel = byte_sel_q;
   assign Busy     = (state_q == LATCH) || (state_q == SHOW);
   assign Done     = (state_q == DONE);
   assign LED      = (state_q == SHOW) ? byte_of(data_q, byte_sel_q) : 8'h00;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: three instances (DWELL = 1, 2, 3) share stimulus
// and are each checked every cycle against an expected-display queue model.
module tb_reg_dump_scanner;

   logic        Clk = 1'b0;
   logic        Reset, Start, Pause;
   logic [4:0]  AF, AL;
   logic [31:0] rf [32];

   logic [4:0]  raddr [3];
   logic [31:0] rdata [3];
   logic [7:0]  led   [3];
   logic [1:0]  bsel  [3];
   logic        busy  [3];
   logic        done  [3];

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign rdata[g] = rf[raddr[g]];
      reg_dump_scanner #(.ADDR_W(5), .DATA_W(32), .DWELL(g + 1)) u_dut (
         .Clk        (Clk),
         .Reset      (Reset),
         .Start      (Start),
         .Pause      (Pause),
         .Addr_First (AF),
         .Addr_Last  (AL),
         .R_Addr     (raddr[g]),
         .R_Data     (rdata[g]),
         .LED        (led[g]),
         .Byte_Sel   (bsel[g]),
         .Busy       (busy[g]),
         .Done       (done[g])
      );
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, idx, $time, act, exp);
      end
   endfunction

   // ---------------- reference model: queue of expected display cycles ----------
   typedef struct {
      int kind;   // 0 latch cycle, 1 show cycle, 2 done cycle
      int addr;
      int bsel;
   } exp_t;

   exp_t        mq [3][512];
   int          head [3];
   int          tail [3];
   logic [31:0] word [3];
   bit          after_rst [3];
   bit          mon_en = 1'b0;
   bit          was_empty;
   exp_t        e;
   logic [4:0]  span, a5;

   initial begin
      for (int i = 0; i < 3; i++) begin
         head[i] = 0; tail[i] = 0; word[i] = '0; after_rst[i] = 1'b0;
      end
   end

   always @(negedge Clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            was_empty = (head[i] == tail[i]);
            if (was_empty) begin
               chk("idle_busy", i, busy[i], 0);
               chk("idle_done", i, done[i], 0);
               chk("idle_led", i, led[i], 0);
               if (after_rst[i]) begin
                  chk("rst_raddr", i, raddr[i], 0);
                  chk("rst_bsel", i, bsel[i], 3);
               end
            end else begin
               e = mq[i][head[i]];
               if (e.kind == 0) begin
                  chk("latch_busy", i, busy[i], 1);
                  chk("latch_done", i, done[i], 0);
                  chk("latch_raddr", i, raddr[i], e.addr);
                  word[i] = rf[e.addr];
                  head[i]++;
               end else if (e.kind == 1) begin
                  chk("show_busy", i, busy[i], 1);
                  chk("show_done", i, done[i], 0);
                  chk("show_raddr", i, raddr[i], e.addr);
                  chk("show_bsel", i, bsel[i], e.bsel);
                  chk("show_led", i, led[i], (word[i] >> (8 * e.bsel)) & 32'hff);
                  if (!Pause) head[i]++;
               end else begin
                  chk("done_pulse", i, done[i], 1);
                  chk("done_busy", i, busy[i], 0);
                  chk("done_led", i, led[i], 0);
                  head[i]++;
               end
            end
            if (Reset) begin
               head[i] = 0; tail[i] = 0; after_rst[i] = 1'b1;
            end else if (was_empty && Start) begin
               after_rst[i] = 1'b0;
               head[i] = 0; tail[i] = 0;
               span = AL - AF;
               for (int a = 0; a <= int'(span); a++) begin
                  a5 = AF + 5'(a);
                  mq[i][tail[i]] = '{kind: 0, addr: int'(a5), bsel: 0};
                  tail[i]++;
                  for (int b = 3; b >= 0; b--) begin
                     for (int d = 0; d < i + 1; d++) begin
                        mq[i][tail[i]] = '{kind: 1, addr: int'(a5), bsel: b};
                        tail[i]++;
                     end
                  end
               end
               mq[i][tail[i]] = '{kind: 2, addr: 0, bsel: 0};
               tail[i]++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic sample();
      @(negedge Clk);
   endtask

   function automatic bit all_idle();
      return (head[0] == tail[0]) && (head[1] == tail[1]) && (head[2] == tail[2]);
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (n < 3000 && !all_idle()) begin
         next_cycle();
         n++;
      end
      chk("idle_timeout", 0, all_idle(), 1);
   endtask

   int done_t [3];
   int busy_n [3];
   int done_n [3];
   int bs2_n  [3];

   task automatic run_scan(input logic [4:0] first, input logic [4:0] last,
                           input int restart_at, input int pause_from,
                           input int pause_len, input bit rnd);
      int cyc;
      for (int i = 0; i < 3; i++) begin
         done_t[i] = -1; busy_n[i] = 0; done_n[i] = 0; bs2_n[i] = 0;
      end
      next_cycle();
      AF = first; AL = last; Start = 1'b1; Pause = 1'b0;
      cyc = 0;
      while (cyc < 3000 && !(done_t[0] >= 0 && done_t[1] >= 0 && done_t[2] >= 0)) begin
         next_cycle();
         cyc++;
         Start = (cyc == restart_at);
         if (rnd) begin
            Pause = ($urandom_range(0, 3) == 0);
            AF = 5'($urandom);
            AL = 5'($urandom);
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
         end else begin
            Pause = (cyc >= pause_from) && (cyc < pause_from + pause_len);
            if (Start) begin
               AF = first ^ 5'h11;
               AL = last + 5'd3;
            end
         end
         sample();
         for (int i = 0; i < 3; i++) begin
            if (busy[i]) busy_n[i]++;
            if (busy[i] && bsel[i] == 2'd2) bs2_n[i]++;
            if (done[i]) begin
               done_n[i]++;
               if (done_t[i] < 0) done_t[i] = cyc;
            end
         end
      end
      for (int i = 0; i < 3; i++) chk("scan_finished", i, done_t[i] >= 0, 1);
      next_cycle();
      Start = 1'b0; Pause = 1'b0;
      wait_idle();
   endtask

   // DWELL=2 instance: exact LED byte sequence for one word at address 3.
   task automatic hand_d2(input logic [31:0] w_exp, input int wr_at, input logic [31:0] wr_val);
      next_cycle();
      AF = 5'd3; AL = 5'd3; Start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         next_cycle();
         Start = 1'b0;
         if (c == wr_at) rf[3] = wr_val;
         sample();
         if (c == 1) begin
            chk("h_latch_raddr", 1, raddr[1], 3);
            chk("h_latch_busy", 1, busy[1], 1);
         end else if (c <= 9) begin
            chk("h_led_seq", 1, led[1], (w_exp >> (8 * (3 - (c - 2) / 2))) & 32'hff);
         end else if (c == 10) begin
            chk("h_done", 1, done[1], 1);
         end else begin
            chk("h_post_led", 1, led[1], 0);
            chk("h_post_busy", 1, busy[1], 0);
            chk("h_post_done", 1, done[1], 0);
         end
      end
      wait_idle();
   endtask

   typedef struct {
      logic [4:0] first;
      logic [4:0] last;
      int         n;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{first: 5'd3,  last: 5'd3,  n: 1};
      tbl[1] = '{first: 5'd30, last: 5'd1,  n: 4};
      tbl[2] = '{first: 5'd10, last: 5'd12, n: 3};
      tbl[3] = '{first: 5'd31, last: 5'd31, n: 1};
      tbl[4] = '{first: 5'd0,  last: 5'd31, n: 32};
      tbl[5] = '{first: 5'd17, last: 5'd16, n: 32};

      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[3] = 32'h12345678;
      Reset = 1'b1; Start = 1'b0; Pause = 1'b0; AF = '0; AL = '0;
      next_cycle();
      mon_en = 1'b1;
      sample();
      for (int i = 0; i < 3; i++) begin
         chk("reset_led", i, led[i], 0);
         chk("reset_bsel", i, bsel[i], 3);
         chk("reset_raddr", i, raddr[i], 0);
         chk("reset_busy", i, busy[i], 0);
         chk("reset_done", i, done[i], 0);
      end
      next_cycle();
      Reset = 1'b0;
      next_cycle();

      // Basic dump, then a write during SHOW that must not disturb the shown word.
      hand_d2(32'h12345678, 0, 32'h0);
      hand_d2(32'h12345678, 4, 32'hAABBCCDD);
      hand_d2(32'hAABBCCDD, 0, 32'h0);

      // Range/length table: busy time and Done timing for every dwell.
      foreach (tbl[k]) begin
         run_scan(tbl[k].first, tbl[k].last, -1, 0, 0, 1'b0);
         for (int i = 0; i < 3; i++) begin
            chk("tbl_busy_len", i, busy_n[i], tbl[k].n * (1 + 4 * (i + 1)));
            chk("tbl_done_time", i, done_t[i], tbl[k].n * (1 + 4 * (i + 1)) + 1);
            chk("tbl_done_count", i, done_n[i], 1);
         end
      end

      // Pause 5 cycles in the middle of byte 2 on the DWELL=3 instance.
      run_scan(5'd3, 5'd3, -1, 6, 5, 1'b0);
      chk("pause_done_time", 2, done_t[2], 14 + 5);
      chk("pause_byte2_hold", 2, bs2_n[2], 8);

      // Second Start with different addresses mid-scan is ignored.
      run_scan(5'd5, 5'd7, 2, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) chk("restart_done_time", i, done_t[i], 3 * (1 + 4 * (i + 1)) + 1);

      // Reset during SHOW of the 2nd of 3 addresses (DWELL=2 instance).
      next_cycle();
      AF = 5'd7; AL = 5'd9; Start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         next_cycle();
         Start = 1'b0;
         Reset = (c == 12);
         sample();
         if (c == 12) chk("pre_rst_raddr", 1, raddr[1], 8);
         if (c == 13) begin
            chk("post_rst_led", 1, led[1], 0);
            chk("post_rst_busy", 1, busy[1], 0);
            chk("post_rst_raddr", 1, raddr[1], 0);
         end
         if (c >= 12) for (int i = 0; i < 3; i++) chk("post_rst_no_done", i, done[i], 0);
      end
      Reset = 1'b0;
      run_scan(5'd7, 5'd9, -1, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) chk("after_rst_done_time", i, done_t[i], 3 * (1 + 4 * (i + 1)) + 1);

      // Randomised scans: pauses, register writes, ignored address/Start changes.
      for (int k = 0; k < 25; k++) begin
         logic [4:0] f, s;
         f = 5'($urandom);
         s = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
         run_scan(f, f + s, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4)) : -1,
                  0, 0, 1'b1);
         for (int i = 0; i < 3; i++) chk("rnd_done_count", i, done_n[i], 1);
      end

      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
